// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start/data/parity/stop bit muxing onto tx_out,
// driving an external shift serializer and cross-checking its bit count.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  load,
  output logic                  ser_en,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  sync_err
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    par_en_reg;
  logic                    par_typ_reg;
  logic                    sync_err_reg;
  logic                    last_bit;
  logic                    sync_mismatch;
  logic [DATA_WIDTH:0]     par_chain;

  // Parity folded bit by bit, seeded with the odd/even select.
  assign par_chain[0] = par_typ_reg;
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ data_reg[gi];
    end
  endgenerate

  assign last_bit      = (bit_cnt_reg == LAST_BIT);
  assign sync_mismatch = (state_reg == DATA) && (ser_done != last_bit);
  assign sync_err      = sync_err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      par_en_reg   <= 1'b0;
      par_typ_reg  <= 1'b0;
      sync_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      // Frame configuration is frozen at acceptance so mid-frame changes are harmless.
      if (load) begin
        data_reg    <= p_data;
        par_en_reg  <= par_en;
        par_typ_reg <= par_typ;
      end
      if (sync_mismatch) begin
        sync_err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    load         = 1'b0;
    ser_en       = 1'b0;
    tx_out       = 1'b1;
    busy         = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (data_valid) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_out       = 1'b0;
        bit_cnt_next = '0;
        state_next   = DATA;
      end
      DATA: begin
        tx_out       = ser_data;
        ser_en       = 1'b1;
        bit_cnt_next = bit_cnt_reg + CW'(1);
        // Leave on whichever comes first so a broken serializer cannot hang the line.
        if (ser_done || last_bit) begin
          state_next = par_en_reg ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx_out     = par_chain[DATA_WIDTH];
        state_next = STOP;
      end
      STOP: begin
        if (data_valid) begin
          load       = 1'b1;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural serializer and a
// scoreboard queue of expected line bits.
module tb_uart_tx_ctrl;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          ser_done, ser_data;
  logic          load, ser_en, tx_out, busy, sync_err;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  bit   early = 1'b0;

  logic [DW-1:0] sr = '0;
  logic [3:0]    scnt = '0;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .p_data(p_data),
    .par_en(par_en), .par_typ(par_typ), .ser_done(ser_done), .ser_data(ser_data),
    .load(load), .ser_en(ser_en), .tx_out(tx_out), .busy(busy), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Serializer model: LSB-first shifter, done flag while the last bit is presented.
  always @(posedge clk) begin
    if (load) begin
      sr   <= p_data;
      scnt <= '0;
    end else if (ser_en) begin
      sr   <= sr >> 1;
      scnt <= scnt + 4'd1;
    end
  end
  assign ser_data = sr[0];
  assign ser_done = early ? (scnt == 4'd6) : (scnt == 4'd7);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt, input int nbits);
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back(logic'(($countones(d) % 2) == 1) ^ pt);
    exp_q.push_back(1'b1);
  endtask

  task automatic request(input logic [DW-1:0] d, input logic pe, input logic pt, input int nbits);
    data_valid = 1'b1;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    #1;
    chk("load_on_request", load, 1);
    push_frame(d, pe, pt, nbits);
  endtask

  task automatic step(input string tag);
    logic e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty observed_tx=%0b", tag, tx_out);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_tx"}, tx_out, e);
      chk({tag, "_busy"}, busy, 1);
      $display("bit %s tx=%0b exp=%0b busy=%0b", tag, tx_out, e, busy);
    end
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_tx"}, tx_out, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pending"}, exp_q.size(), 0);
    $display("idle %s tx=%0b busy=%0b", tag, tx_out, busy);
  endtask

  initial begin
    #1;
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_load", load, 0);
    chk("rst_ser_en", ser_en, 0);
    chk("rst_sync_err", sync_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_chk("idle0");

    // 0xA5 even parity, 11-bit frame; load must drop once START is reached
    request(8'hA5, 1'b1, 1'b0, DW);
    step("a5_even");
    chk("load_1clk", load, 0);
    data_valid = 1'b0;
    repeat (10) step("a5_even");
    idle_chk("after_a5_even");

    // 0xA5 odd parity
    request(8'hA5, 1'b1, 1'b1, DW);
    step("a5_odd");
    data_valid = 1'b0;
    repeat (10) step("a5_odd");
    idle_chk("after_a5_odd");

    // 0xA5 no parity, 10-bit frame
    request(8'hA5, 1'b0, 1'b0, DW);
    step("a5_nopar");
    data_valid = 1'b0;
    repeat (9) step("a5_nopar");
    idle_chk("after_a5_nopar");

    // Back-to-back 0x00 then 0xFF with data_valid held through STOP
    request(8'h00, 1'b0, 1'b0, DW);
    step("b2b_0");
    p_data = 8'hFF;
    push_frame(8'hFF, 1'b0, 1'b0, DW);
    repeat (9) step("b2b_0");
    step("b2b_1");
    data_valid = 1'b0;
    repeat (9) step("b2b_1");
    idle_chk("after_b2b");

    // Request pulse during DATA of 0x81 must be ignored
    request(8'h81, 1'b0, 1'b0, DW);
    step("ign");
    data_valid = 1'b0;
    repeat (3) step("ign");
    data_valid = 1'b1;
    p_data     = 8'h3C;
    par_en     = 1'b1;
    #1;
    chk("ign_load_busy", load, 0);
    step("ign");
    data_valid = 1'b0;
    par_en     = 1'b0;
    repeat (5) step("ign");
    idle_chk("after_ign");
    chk("sync_err_clean", sync_err, 0);

    // Serializer reports done one bit early: 7 data bits, sticky sync_err
    early = 1'b1;
    request(8'hA5, 1'b0, 1'b0, DW - 1);
    step("early");
    data_valid = 1'b0;
    repeat (8) step("early");
    idle_chk("after_early");
    chk("sync_err_set", sync_err, 1);
    early = 1'b0;
    request(8'h3C, 1'b0, 1'b0, DW);
    step("post_early");
    data_valid = 1'b0;
    repeat (9) step("post_early");
    idle_chk("after_post_early");
    chk("sync_err_sticky", sync_err, 1);

    // Reset in the middle of DATA aborts the frame immediately
    request(8'h81, 1'b1, 1'b0, DW);
    step("abort");
    data_valid = 1'b0;
    repeat (3) step("abort");
    chk("abort_ser_en_before", ser_en, 1);
    rst = 1'b0;
    #1;
    chk("abort_tx", tx_out, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ser_en", ser_en, 0);
    chk("abort_sync_err", sync_err, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    idle_chk("post_rst0");
    idle_chk("post_rst1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
